core_avl_ram_slave: RTL and testbench

Word-organised on-chip data RAM that acts as the responder on the `i_avl_bus` protocol driven by the core's load/store unit. It accepts single and burst read/write requests with per-byte enables and returns read beats in order on `read_data`/`read_data_valid`, honouring the master's `resp_ready`. It sits on the slave side of the data bus, directly or behind the bus interconnect, as the core's tightly coupled data memory.

---
 rtl/core_avl_ram_slave.sv | 101 ++++++++++
 tb/tb_core_avl_ram_slave.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_avl_ram_slave.sv
// core_avl_ram_slave: word-organised data RAM answering single and burst
// requests on the core's Avalon-style data bus, with in-order read beats.
module core_avl_ram_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int BURST_W     = 8
) (
    input  logic               clk,
    input  logic               rest,
    input  logic [31:0]        avl_s0_address,
    input  logic               avl_s0_read,
    input  logic               avl_s0_write,
    input  logic [3:0]         avl_s0_byte_en,
    input  logic [31:0]        avl_s0_write_data,
    input  logic               avl_s0_begin_burst_transfer,
    input  logic [BURST_W-1:0] avl_s0_burst_count,
    output logic               avl_s0_request_ready,
    output logic [31:0]        avl_s0_read_data,
    output logic               avl_s0_read_data_valid,
    input  logic               avl_s0_resp_ready
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

    state_t             state_q;
    logic [AW-1:0]      ptr_q;
    logic [BURST_W-1:0] rem_q;
    logic [31:0]        rdata_q;
    logic               rvalid_q;
    logic [31:0]        mem [DEPTH_WORDS];

    logic          stall;
    logic          we;
    logic          multi;
    logic          last;
    logic [AW-1:0] idx;
    logic [AW-1:0] waddr;

    assign stall = rvalid_q && !avl_s0_resp_ready;
    assign idx   = avl_s0_address[2 +: AW];
    // a count of 0 or 1 is a plain single transfer
    assign multi = avl_s0_begin_burst_transfer && (avl_s0_burst_count > BURST_W'(1));
    assign last  = rem_q == BURST_W'(1);

    assign avl_s0_request_ready   = !rest && !stall && (state_q != RD_BURST);
    assign we                     = avl_s0_request_ready && avl_s0_write;
    assign waddr                  = (state_q == WR_BURST) ? ptr_q : idx;
    assign avl_s0_read_data       = rdata_q;
    assign avl_s0_read_data_valid = rvalid_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (we && avl_s0_byte_en[b]) mem[waddr][8*b +: 8] <= avl_s0_write_data[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            rem_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else if (!stall) begin
            case (state_q)
                IDLE: begin
                    rvalid_q <= 1'b0;
                    if (avl_s0_write) begin
                        if (multi) begin
                            ptr_q   <= idx + AW'(1);
                            rem_q   <= avl_s0_burst_count - BURST_W'(1);
                            state_q <= WR_BURST;
                        end
                    end else if (avl_s0_read) begin
                        rdata_q  <= mem[idx];
                        rvalid_q <= 1'b1;
                        if (multi) begin
                            ptr_q   <= idx + AW'(1);
                            rem_q   <= avl_s0_burst_count - BURST_W'(1);
                            state_q <= RD_BURST;
                        end
                    end
                end
                RD_BURST: begin
                    rdata_q  <= mem[ptr_q];
                    rvalid_q <= 1'b1;
                    ptr_q    <= ptr_q + AW'(1);
                    rem_q    <= rem_q - BURST_W'(1);
                    if (last) state_q <= IDLE;
                end
                WR_BURST: begin
                    if (avl_s0_write) begin
                        ptr_q <= ptr_q + AW'(1);
                        rem_q <= rem_q - BURST_W'(1);
                        if (last) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_avl_ram_slave.sv
// tb_core_avl_ram_slave: table-driven single accesses plus burst, stall, wrap
// and reset-abort sequences; read beats checked against a data/cycle scoreboard.
module tb_core_avl_ram_slave;
    logic        clk = 1'b0;
    logic        rest = 1'b1;
    logic [31:0] address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        bb = 1'b0;
    logic [7:0]  cnt = '0;
    logic        rr;
    logic [31:0] rdata;
    logic        vld;
    logic        resp_ready = 1'b1;

    core_avl_ram_slave #(.DEPTH_WORDS(1024), .BURST_W(8)) dut (
        .clk                         (clk),
        .rest                        (rest),
        .avl_s0_address              (address),
        .avl_s0_read                 (read),
        .avl_s0_write                (write),
        .avl_s0_byte_en              (be),
        .avl_s0_write_data           (wdata),
        .avl_s0_begin_burst_transfer (bb),
        .avl_s0_burst_count          (cnt),
        .avl_s0_request_ready        (rr),
        .avl_s0_read_data            (rdata),
        .avl_s0_read_data_valid      (vld),
        .avl_s0_resp_ready           (resp_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        int          c;
    } beat_t;
    beat_t sb[$];

    typedef struct {
        bit          wr;
        bit          rd;
        bit          bb;
        logic [7:0]  cnt;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[17];

    int checks = 0;
    int errors = 0;
    logic [31:0] d4 [4];
    logic [31:0] e8 [8];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // a beat is consumed at the edge following a negedge where valid && resp_ready
    always @(negedge clk) begin
        beat_t b;
        if (!rest && vld && resp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h expected none", rdata);
            end else begin
                b = sb.pop_front();
                chk("beat_data", rdata, b.d);
                chk("beat_cycle", cyc, b.c);
            end
        end
    end

    task automatic wr_burst(input logic [31:0] a, input int n, input logic [31:0] d [4], input int bubble);
        for (int i = 0; i < n; i++) begin
            address = (i == 0) ? a : 32'hFFFF_FFFF;
            bb      = (i == 0);
            cnt     = n[7:0];
            write   = 1'b1;
            be      = 4'hF;
            wdata   = d[i];
            @(negedge clk);
            chk("wb_ready", rr, 1);
            tick();
            if (i + 1 == bubble) begin
                write   = 1'b0;
                read    = 1'b1;
                address = 32'h10;
                @(negedge clk);
                chk("wb_bubble_ready", rr, 1);
                tick();
                read = 1'b0;
            end
        end
        write = 1'b0;
        bb    = 1'b0;
    endtask

    task automatic rd_burst(input logic [31:0] a, input int n, input logic [31:0] e [8], input int sbeat, input int slen);
        int c;
        address = a;
        read    = 1'b1;
        bb      = 1'b1;
        cnt     = n[7:0];
        @(negedge clk);
        chk("rb_accept", rr, 1);
        c = cyc;
        for (int k = 1; k <= n; k++)
            sb.push_back('{e[k-1], c + k + ((sbeat > 0 && k >= sbeat) ? slen : 0)});
        tick();
        read = 1'b0;
        bb   = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (k == sbeat) begin
                resp_ready = 1'b0;
                repeat (slen) begin
                    @(negedge clk);
                    chk("stall_valid", vld, 1);
                    chk("stall_hold", rdata, e[k-1]);
                    chk("stall_ready", rr, 0);
                    tick();
                end
                resp_ready = 1'b1;
            end
            @(negedge clk);
            chk("rb_valid", vld, 1);
            chk("rb_ready", rr, (k == n) ? 1 : 0);
            tick();
        end
        @(negedge clk);
        chk("rb_done", vld, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1, 0, 0, 0, 32'h0000_0010, 4'h1, 32'h000000AA, 32'h0};
        tbl[2]  = '{0, 1, 0, 0, 32'h0000_0010, 4'h0, 32'h0,        32'hDEADBEAA};
        tbl[3]  = '{1, 0, 1, 1, 32'h0000_0020, 4'hF, 32'h11223344, 32'h0};
        tbl[4]  = '{1, 0, 0, 0, 32'h0000_0020, 4'h6, 32'h00AABB00, 32'h0};
        tbl[5]  = '{0, 1, 1, 0, 32'h0000_0020, 4'h0, 32'h0,        32'h11AABB44};
        tbl[6]  = '{1, 0, 0, 0, 32'h1000_0010, 4'h8, 32'h55000000, 32'h0};
        tbl[7]  = '{0, 1, 0, 0, 32'h0000_0013, 4'h0, 32'h0,        32'h55ADBEAA};
        tbl[8]  = '{0, 1, 0, 0, 32'h0000_0020, 4'h0, 32'h0,        32'h11AABB44};
        tbl[9]  = '{1, 1, 0, 0, 32'h0000_0030, 4'hF, 32'h0BADF00D, 32'h0};
        tbl[10] = '{0, 1, 0, 0, 32'h0000_0030, 4'h0, 32'h0,        32'h0BADF00D};
        tbl[11] = '{1, 0, 0, 0, 32'h0000_0020, 4'h0, 32'hFFFFFFFF, 32'h0};
        tbl[12] = '{0, 1, 0, 0, 32'h0000_1020, 4'h0, 32'h0,        32'h11AABB44};
        tbl[13] = '{1, 0, 0, 0, 32'h0000_0FFC, 4'hF, 32'hCAFEF00D, 32'h0};
        tbl[14] = '{0, 1, 0, 0, 32'hFFFF_FFFC, 4'h0, 32'h0,        32'hCAFEF00D};
        tbl[15] = '{1, 0, 0, 0, 32'h0000_0000, 4'hF, 32'h600DCAFE, 32'h0};
        tbl[16] = '{0, 1, 0, 0, 32'h8000_0000, 4'h0, 32'h0,        32'h600DCAFE};

        tick();
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", rr, 0);
            chk("rst_valid", vld, 0);
            chk("rst_data", rdata, 0);
            tick();
        end
        rest = 1'b0;
        @(negedge clk);
        chk("idle_ready", rr, 1);
        chk("idle_valid", vld, 0);
        chk("idle_data", rdata, 0);
        tick();

        foreach (tbl[i]) begin
            write   = tbl[i].wr;
            read    = tbl[i].rd;
            bb      = tbl[i].bb;
            cnt     = tbl[i].cnt;
            address = tbl[i].addr;
            be      = tbl[i].be;
            wdata   = tbl[i].wdata;
            @(negedge clk);
            chk("tbl_ready", rr, 1);
            if (tbl[i].rd && !tbl[i].wr) sb.push_back('{tbl[i].exp, cyc + 1});
            tick();
        end
        write = 1'b0;
        read  = 1'b0;
        bb    = 1'b0;
        tick();

        d4 = '{32'd1, 32'd2, 32'd3, 32'd4};
        wr_burst(32'h100, 4, d4, 2);
        e8 = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0};
        rd_burst(32'h100, 4, e8, 0, 0);

        d4 = '{32'hA1, 32'hA2, 32'hA3, 32'h0};
        wr_burst(32'h200, 3, d4, 0);
        e8 = '{32'hA1, 32'hA2, 32'hA3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        rd_burst(32'h200, 3, e8, 2, 2);

        d4 = '{32'h77777777, 32'h88888888, 32'h0, 32'h0};
        wr_burst(32'hFFC, 2, d4, 0);
        e8 = '{32'h77777777, 32'h88888888, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        rd_burst(32'hABCD_EFFC, 2, e8, 0, 0);
        e8[0] = 32'h88888888;
        rd_burst(32'h4000_0000, 1, e8, 0, 0);

        address = 32'h100;
        read    = 1'b1;
        bb      = 1'b1;
        cnt     = 8'd8;
        @(negedge clk);
        chk("abort_accept", rr, 1);
        sb.push_back('{32'd1, cyc + 1});
        tick();
        read = 1'b0;
        bb   = 1'b0;
        @(negedge clk);
        tick();
        rest = 1'b1;
        @(negedge clk);
        chk("abort_rst_ready", rr, 0);
        tick();
        rest = 1'b0;
        @(negedge clk);
        chk("abort_data", rdata, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_valid", vld, 0);
            chk("abort_idle_ready", rr, 1);
            tick();
        end
        e8[0] = 32'd1;
        rd_burst(32'h100, 1, e8, 0, 0);
        e8[0] = 32'h55ADBEAA;
        rd_burst(32'h10, 1, e8, 0, 0);

        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
